riscv_store_buffer: RTL and testbench
=====================================

// Module: riscv_store_buffer
// PURPOSE
//  Store buffer between the RISC-V datapath's data-memory port and the data memory.
//  It queues sw/sh/sb writes so the core never waits on memory write latency.
//  Queued stores drain to memory in order.
//  Loads read memory through a combinational read port.
//  Buffered bytes are merged in per byte, youngest first, so a load always sees program-order data.
// PARAMETERS
//  DEPTH  4  number of queued stores; power of two, >= 2
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  cpu_we     in   1   store request this cycle
//  cpu_addr   in   32  byte address of load/store; bits [1:0] ignored (word-aligned entries)
//  cpu_wdata  in   32  store data, already lane-aligned
//  cpu_be     in   4   byte enables for store; bit i covers wdata[8i+7:8i]
//  cpu_rdata  out  32  load data = mem_rdata merged with buffered bytes (combinational)
//  cpu_stall  out  1   store cannot be accepted this cycle; core must hold the instruction
//  mem_raddr  out  32  = {cpu_addr[31:2],2'b00}, combinational
//  mem_rdata  in   32  memory read data for mem_raddr, same cycle
//  mem_we     out  1   head entry valid and presented to memory
//  mem_waddr  out  32  head entry word address, {addr,2'b00}
//  mem_wdata  out  32  head entry data
//  mem_be     out  4   head entry byte enables
//  mem_ready  in   1   memory accepts the presented write at this posedge
//  sb_empty   out  1   no entries queued (used for fences/halt checks)
// BEHAVIOUR
//  Reset:
//   - head=tail=count=0 and all entry valid bits cleared.
//   - Outputs after reset: mem_we=0, sb_empty=1, cpu_stall=0.
//   - Entry data/addr contents are don't-care.
//   - Reset asserted mid-drain discards all queued stores; no write is issued in the reset cycle.
//  Enqueue:
//   - When cpu_we && !cpu_stall, store {addr[31:2],wdata,be} at tail at the posedge.
//   - Advance tail (wraps modulo DEPTH) and increment count.
//   - cpu_be==0 still enqueues (harmless write).
//  Stall:
//   - cpu_stall = cpu_we && (count==DEPTH).
//   - A pop in the same cycle does NOT clear the stall; the core retries next cycle.
//   - This keeps cpu_stall independent of mem_ready (no comb path mem_ready->cpu_stall).
//  Drain:
//   - mem_we = (count!=0); mem_* show the head entry.
//   - Pop at the posedge where mem_we && mem_ready: advance head (wraps) and decrement count.
//   - Entries retire strictly in enqueue order; at most one per cycle.
//  Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
//  With count==0, a push enqueues; mem_we rises next cycle (latency 1, no bypass to memory).
//  Load merge (combinational, all entries):
//   - For each byte lane i, take the youngest valid entry with matching word addr and be[i]=1; else mem_rdata.
//   - An entry popping this cycle still counts (memory not yet updated).
//   - The merge is evaluated for any cpu_addr; the core ignores cpu_rdata for non-loads.
//  Youngest-first ordering is by distance from head modulo DEPTH, not by physical index (wrap-around correctness).
//  FSM: none beyond the count; occupancy states EMPTY / PARTIAL / FULL are derived from count.
// STRUCTURE
//  - Shared header riscv/store_buffer.svh holds:
//    - typedef struct packed {logic [29:0] waddr; logic [31:0] data; logic [3:0] be;} sb_entry_t;
//    - SB_WORD_ADDR(a) macro.
//  - One sub-module, sb_fifo: a circular buffer of sb_entry_t with push/pop/count/full/empty.
//    It exposes all entries plus the head index for the merge logic.
//  - The merge lives in riscv_store_buffer as a loop from oldest to youngest, the youngest overwriting.
// TESTING
//  1. After reset: sb_empty=1, mem_we=0, cpu_stall=0; mem_rdata=0xdeadbeef at 0x24 -> cpu_rdata=0xdeadbeef.
//  2. Hold mem_ready=0 and store 37 to 0x20 with be=4'hf.
//     Next cycle mem_we=1, mem_waddr=0x20, mem_wdata=37.
//     Load 0x20 with mem_rdata=0xdeadc0de -> cpu_rdata=37.
//  3. Ordering and merge, mem_ready=0:
//     - sw 0x11223344 to 0x24, then sb be=4'b0010 data 0x0000AA00 to 0x24, with mem_rdata=0xdeadbeef.
//     - Load 0x24 -> 0x1122AA44.
//     - Raise mem_ready: writes issue in order (be 4'hf, then 4'b0010) on consecutive cycles.
//  4. Full and stall, mem_ready=0:
//     - Enqueue 4 stores; 5th cpu_we -> cpu_stall=1, count stays 4.
//     - Raise mem_ready for 1 cycle: stall persists that cycle and clears the next; 5th store is accepted and count=4.
//  5. Wrap-around:
//     - Fill, drain 3, push 3 more to the same word 0x28 with data 1,2,3.
//     - Load 0x28 -> 3 (youngest across the pointer wrap).
//     - Memory finally holds 3 and sb_empty=1.
//  6. Reset mid-drain with 3 entries queued: assert rst for 1 cycle -> mem_we=0, sb_empty=1, and no further writes occur.

Source files
------------

// File: rtl/riscv_store_buffer_pkg.sv
// Shared types and helpers for the RISC-V store buffer.
package riscv_store_buffer_pkg;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    // Word-aligned byte address; the low two address bits never select an entry.
    function automatic logic [31:0] sb_word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_store_buffer_if.sv
// Core-side and memory-side signals of the store buffer, bundled as one bus.
interface riscv_store_buffer_if;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        sb_empty;

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ready,
        output cpu_rdata, cpu_stall, mem_raddr, mem_we, mem_waddr, mem_wdata,
               mem_be, sb_empty
    );

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_stall, mem_raddr, mem_we, mem_waddr, mem_wdata,
               mem_be, sb_empty
    );
endinterface

// File: rtl/riscv_store_buffer_sb_fifo.sv
// Circular buffer of store entries; exposes every slot and the head index for load merging.
module sb_fifo
    import riscv_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  sb_entry_t               din,
    output sb_entry_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]        valid,
    output logic [PW-1:0]           head,
    output logic [PW:0]             count,
    output logic                    full,
    output logic                    empty
);
    logic [PW-1:0] tail;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            // Push and pop never share a slot: pop needs count>0, push needs count<DEPTH.
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; slot validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= din;
    end
endmodule

// File: rtl/riscv_store_buffer.sv
// Store buffer: queues core stores, drains them in order, and merges queued bytes into loads.
module riscv_store_buffer
    import riscv_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_store_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         head;
    logic [PW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [31:0]           cpu_word;
    sb_entry_t             din;
    sb_entry_t             head_entry;
    logic [PW-1:0]         idx;
    logic [31:0]           merged;

    assign cpu_word = sb_word_addr(bus.cpu_addr);

    // Stall looks only at occupancy so mem_ready has no path to cpu_stall.
    assign bus.cpu_stall = bus.cpu_we && full;
    assign push          = bus.cpu_we && !full;
    assign pop           = bus.mem_we && bus.mem_ready;

    assign din.waddr = cpu_word[31:2];
    assign din.data  = bus.cpu_wdata;
    assign din.be    = bus.cpu_be;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign head_entry    = entries[head];
    // No write is presented while reset is held, even with entries still queued.
    assign bus.mem_we    = !empty && !rst;
    assign bus.mem_waddr = {head_entry.waddr, 2'b00};
    assign bus.mem_wdata = head_entry.data;
    assign bus.mem_be    = head_entry.be;
    assign bus.mem_raddr = cpu_word;
    assign bus.sb_empty  = empty;

    // Walk from oldest (head) to youngest so younger matching bytes overwrite older ones.
    always_comb begin
        merged = bus.mem_rdata;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && ({entries[idx].waddr, 2'b00} == cpu_word)) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[idx].be[b]) merged[8*b +: 8] = entries[idx].data[8*b +: 8];
                end
            end
        end
    end

    assign bus.cpu_rdata = merged;
endmodule

// File: tb/tb_riscv_store_buffer.sv
// Directed bench for riscv_store_buffer with a write-order scoreboard and a small memory model.
module tb_riscv_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk;
    logic rst;
    riscv_store_buffer_if bus();

    riscv_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t         exp_q[$];
    logic [31:0] mem_model [0:63];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: predict stall/mem_we, score any write, then advance to the next negedge.
    task automatic tick();
        bit  push_ok;
        wr_t e;
        #1;
        if (rst) begin
            exp_q.delete();
            check("mem_we_in_reset", 32'(bus.mem_we), 32'd0);
        end else begin
            check("mem_we", 32'(bus.mem_we), 32'(exp_q.size() != 0));
            check("sb_empty", 32'(bus.sb_empty), 32'(exp_q.size() == 0));
            check("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_we && exp_q.size() == DEPTH));
            push_ok = bus.cpu_we && (exp_q.size() < DEPTH);
            if (exp_q.size() != 0 && bus.mem_ready) begin
                e = exp_q.pop_front();
                check("mem_waddr", bus.mem_waddr, e.addr);
                check("mem_wdata", bus.mem_wdata, e.data);
                check("mem_be", 32'(bus.mem_be), 32'(e.be));
                for (int b = 0; b < 4; b++)
                    if (e.be[b]) mem_model[e.addr[7:2]][8*b +: 8] = e.data[8*b +: 8];
            end
            if (push_ok) begin
                e.addr = bus.cpu_addr & 32'hFFFF_FFFC;
                e.data = bus.cpu_wdata;
                e.be   = bus.cpu_be;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_be    = be;
        tick();
        bus.cpu_we    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = 32'd0;
        rst           = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.cpu_be    = 4'h0;
        bus.mem_rdata = 32'd0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state and pass-through load
        bus.cpu_addr  = 32'h24;
        bus.mem_rdata = 32'hdeadbeef;
        #1;
        check("rst_sb_empty", 32'(bus.sb_empty), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'hdeadbeef);
        check("mem_raddr", bus.mem_raddr, 32'h24);
        bus.cpu_addr = 32'h27;
        #1;
        check("mem_raddr_align", bus.mem_raddr, 32'h24);

        // Single store, latency 1, full-word forward
        store(32'h20, 32'd37, 4'hf);
        #1;
        check("st1_mem_we", 32'(bus.mem_we), 32'd1);
        check("st1_waddr", bus.mem_waddr, 32'h20);
        check("st1_wdata", bus.mem_wdata, 32'd37);
        bus.cpu_addr  = 32'h20;
        bus.mem_rdata = 32'hdeadc0de;
        #1;
        check("st1_fwd", bus.cpu_rdata, 32'd37);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("st1_mem", mem_model[8], 32'd37);

        // Byte merge, youngest over oldest, then in-order drain
        store(32'h24, 32'h11223344, 4'hf);
        store(32'h24, 32'h0000AA00, 4'b0010);
        bus.cpu_addr  = 32'h24;
        bus.mem_rdata = 32'hdeadbeef;
        #1;
        check("merge_rdata", bus.cpu_rdata, 32'h1122AA44);
        bus.cpu_addr = 32'h2c;
        #1;
        check("merge_other_word", bus.cpu_rdata, 32'hdeadbeef);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        check("merge_mem", mem_model[9], 32'h1122AA44);

        // Full and stall
        for (int i = 0; i < DEPTH; i++) store(32'h30 + 32'(4*i), 32'h100 + 32'(i), 4'hf);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h40;
        bus.cpu_wdata = 32'h555;
        bus.cpu_be    = 4'hf;
        #1;
        check("full_stall", 32'(bus.cpu_stall), 32'd1);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        check("stall_during_pop", 32'(bus.cpu_stall), 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("stall_cleared", 32'(bus.cpu_stall), 32'd0);
        tick();
        #1;
        check("refull_stall", 32'(bus.cpu_stall), 32'd1);
        bus.cpu_we = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (DEPTH) tick();
        bus.mem_ready = 1'b0;
        check("full_mem_last", mem_model[16], 32'h555);

        // Shift pointers by two so the 0x28 stores straddle the physical wrap
        store(32'h00, 32'h0, 4'h0);
        store(32'h04, 32'h0, 4'h0);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        store(32'h10, 32'haa, 4'hf);
        store(32'h14, 32'hbb, 4'hf);
        store(32'h18, 32'hcc, 4'hf);
        store(32'h28, 32'h99, 4'hf);
        bus.mem_ready = 1'b1;
        repeat (3) tick();
        bus.mem_ready = 1'b0;
        store(32'h28, 32'd1, 4'hf);
        store(32'h28, 32'd2, 4'hf);
        store(32'h28, 32'd3, 4'hf);
        bus.cpu_addr  = 32'h28;
        bus.mem_rdata = 32'h0;
        #1;
        check("wrap_fwd", bus.cpu_rdata, 32'd3);
        bus.mem_ready = 1'b1;
        repeat (DEPTH) tick();
        bus.mem_ready = 1'b0;
        check("wrap_mem", mem_model[10], 32'd3);
        check("wrap_empty", 32'(bus.sb_empty), 32'd1);

        // Reset with three queued stores discards them
        store(32'h34, 32'hf0, 4'hf);
        store(32'h38, 32'hf1, 4'hf);
        store(32'h3c, 32'hf2, 4'hf);
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mid_empty", 32'(bus.sb_empty), 32'd1);
        repeat (3) tick();
        bus.mem_ready = 1'b0;
        check("rst_mid_mem", mem_model[13], 32'h101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
